// File: rtl/softmax_exp_sequencer.sv
// Softmax exp sequencer: buffers one vector and tracks its maximum, then time-shares a single
// exp unit over (x - max). Results are streamed out and summed for the normaliser.
module softmax_exp_sequencer #(
    parameter int LEN   = 16,
    parameter int DEPTH = 8,
    parameter int SUM_W = LEN + $clog2(DEPTH)
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic signed [LEN-1:0]    in_data_i,
    output logic signed [LEN-1:0]    exp_angle_o,
    input  logic        [LEN-1:0]    exp_value_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic        [LEN-1:0]    out_data_o,
    output logic [$clog2(DEPTH)-1:0] out_idx_o,
    output logic                     out_last_o,
    output logic                     sum_valid_o,
    output logic        [SUM_W-1:0]  sum_data_o
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic [1:0] {LOAD, EXP, DRAIN, DONE} state_e;

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        cnt_q, cnt_d;
    logic signed [LEN-1:0]   maxVal_q, maxVal_d;
    logic [SUM_W-1:0]        sumAcc_q, sumAcc_d;
    logic                    outValid_q, outValid_d;
    logic [LEN-1:0]          outData_q, outData_d;
    logic [IDX_W-1:0]        outIdx_q, outIdx_d;
    logic                    outLast_q, outLast_d;
    logic                    sumValid_q, sumValid_d;
    logic [SUM_W-1:0]        sumData_q, sumData_d;
    logic signed [LEN-1:0]   bufMem_q [DEPTH];

    logic                    issue;
    logic signed [LEN:0]     angleDiff;

    assign in_ready_o  = rst_n_i && (state_q == LOAD);
    assign issue       = (state_q == EXP) && (!outValid_q || out_ready_i);

    assign out_valid_o = outValid_q;
    assign out_data_o  = outData_q;
    assign out_idx_o   = outIdx_q;
    assign out_last_o  = outLast_q;
    assign sum_valid_o = sumValid_q;
    assign sum_data_o  = sumData_q;

    // max is never below any buffered sample, so the difference only saturates on the negative side
    always_comb begin
        angleDiff   = {bufMem_q[cnt_q][LEN-1], bufMem_q[cnt_q]} - {maxVal_q[LEN-1], maxVal_q};
        exp_angle_o = '0;
        if (state_q == EXP) begin
            if (angleDiff[LEN] != angleDiff[LEN-1]) begin
                exp_angle_o = {1'b1, {(LEN-1){1'b0}}};
            end else begin
                exp_angle_o = angleDiff[LEN-1:0];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        maxVal_d   = maxVal_q;
        sumAcc_d   = sumAcc_q;
        outValid_d = outValid_q;
        outData_d  = outData_q;
        outIdx_d   = outIdx_q;
        outLast_d  = outLast_q;
        sumValid_d = sumValid_q;
        sumData_d  = sumData_q;

        if (outValid_q && out_ready_i && !issue) begin
            outValid_d = 1'b0;
        end

        unique case (state_q)
            LOAD: begin
                if (in_valid_i) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == '0 || in_data_i > maxVal_q) begin
                        maxVal_d = in_data_i;
                    end
                    if (cnt_q == LAST_IDX) begin
                        state_d  = EXP;
                        cnt_d    = '0;
                        sumAcc_d = '0;
                    end
                end
            end
            EXP: begin
                if (issue) begin
                    outData_d  = exp_value_i;
                    outIdx_d   = cnt_q;
                    outLast_d  = (cnt_q == LAST_IDX);
                    outValid_d = 1'b1;
                    sumAcc_d   = sumAcc_q + SUM_W'(exp_value_i);
                    cnt_d      = cnt_q + 1'b1;
                    if (cnt_q == LAST_IDX) begin
                        state_d = DRAIN;
                        cnt_d   = '0;
                    end
                end
            end
            DRAIN: begin
                if (outValid_q && out_ready_i) begin
                    sumData_d  = sumAcc_q;
                    sumValid_d = 1'b1;
                    state_d    = DONE;
                end
            end
            DONE: begin
                sumValid_d = 1'b0;
                state_d    = LOAD;
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q    <= LOAD;
            cnt_q      <= '0;
            maxVal_q   <= '0;
            sumAcc_q   <= '0;
            outValid_q <= 1'b0;
            outData_q  <= '0;
            outIdx_q   <= '0;
            outLast_q  <= 1'b0;
            sumValid_q <= 1'b0;
            sumData_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            maxVal_q   <= maxVal_d;
            sumAcc_q   <= sumAcc_d;
            outValid_q <= outValid_d;
            outData_q  <= outData_d;
            outIdx_q   <= outIdx_d;
            outLast_q  <= outLast_d;
            sumValid_q <= sumValid_d;
            sumData_q  <= sumData_d;
        end
    end

    // Sample storage needs no reset: entries are always rewritten before they are read
    always_ff @(posedge clk_i) begin
        if (in_ready_o && in_valid_i) begin
            bufMem_q[cnt_q] <= in_data_i;
        end
    end

endmodule
